// File: rtl/el2_pkg.sv
// Shared types and constants for the debug abstract-command sequencer.
package el2_pkg;

    localparam int unsigned DBG_ADDR_W = 32;
    localparam int unsigned DBG_DATA_W = 32;
    localparam int unsigned DBG_ERR_W  = 3;

    typedef enum logic [2:0] {
        DBG_IDLE      = 3'd0,
        DBG_WAIT_IDLE = 3'd1,
        DBG_ISSUE     = 3'd2,
        DBG_WAIT_DONE = 3'd3,
        DBG_RESP      = 3'd4
    } el2_dbg_seq_state_t;

    typedef struct packed {
        logic                  write;
        logic [1:0]            cmd_type;
        logic [DBG_ADDR_W-1:0] addr;
        logic [DBG_DATA_W-1:0] wrdata;
        logic [1:0]            size;
    } el2_dbg_cmd_pkt_t;

    localparam logic [1:0] DBG_TYPE_GPR  = 2'd0;
    localparam logic [1:0] DBG_TYPE_CSR  = 2'd1;
    localparam logic [1:0] DBG_TYPE_MEM  = 2'd2;
    localparam logic [1:0] DBG_TYPE_RSVD = 2'd3;

    localparam logic [DBG_ERR_W-1:0] DBG_ERR_NONE   = 3'd0;
    localparam logic [DBG_ERR_W-1:0] DBG_ERR_NOTSUP = 3'd2;
    localparam logic [DBG_ERR_W-1:0] DBG_ERR_EXC    = 3'd3;
    localparam logic [DBG_ERR_W-1:0] DBG_ERR_HALT   = 3'd4;
    localparam logic [DBG_ERR_W-1:0] DBG_ERR_BUS    = 3'd5;
    localparam logic [DBG_ERR_W-1:0] DBG_ERR_OTHER  = 3'd7;

endpackage

// File: rtl/el2_dbg_cmd_timer.sv
// Saturating wait counter; expired once the count reaches all-ones.
module el2_dbg_cmd_timer #(
    parameter int unsigned TIMEOUT_W = 8
) (
    input  logic clk,
    input  logic rst_l,
    input  logic clr,
    input  logic inc,
    output logic expired
);

    logic [TIMEOUT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && !expired) begin
            cnt <= cnt + TIMEOUT_W'(1);
        end
    end

    assign expired = &cnt;

endmodule

// File: rtl/el2_dbg_cmd_seq.sv
// Abstract-command sequencer: precondition checks, single-cycle injection
// strobe toward decode/LSU, completion/timeout wait and registered response.
module el2_dbg_cmd_seq
    import el2_pkg::*;
#(
    parameter int unsigned TIMEOUT_W = 8
) (
    input  logic        clk,
    input  logic        rst_l,
    input  logic        dm_cmd_valid,
    output logic        dm_cmd_ready,
    input  logic        dm_cmd_write,
    input  logic [1:0]  dm_cmd_type,
    input  logic [31:0] dm_cmd_addr,
    input  logic [31:0] dm_cmd_wrdata,
    input  logic [1:0]  dm_cmd_size,
    input  logic        core_halted,
    input  logic        core_idle,
    output logic        dbg_cmd_valid,
    output logic        dbg_cmd_write,
    output logic [1:0]  dbg_cmd_type,
    output logic [31:0] dbg_cmd_addr,
    output logic [31:0] dbg_cmd_wrdata,
    output logic [1:0]  dbg_cmd_size,
    input  logic        dbg_cmd_done,
    input  logic        dbg_cmd_fail,
    input  logic [31:0] dbg_rddata,
    output logic        dm_rsp_valid,
    input  logic        dm_rsp_ready,
    output logic [2:0]  dm_rsp_cmderr,
    output logic [31:0] dm_rsp_data
);

    el2_dbg_seq_state_t    state, state_nxt;
    el2_dbg_cmd_pkt_t      pkt_q;
    logic                  accept_c;
    logic                  timer_clr_c;
    logic                  expired;
    logic [DBG_ERR_W-1:0]  err_c;
    logic [DBG_DATA_W-1:0] data_c;

    logic                  cmd_ready_nxt, cmd_valid_nxt, rsp_valid_nxt;
    logic [DBG_ERR_W-1:0]  cmderr_nxt;
    logic [DBG_DATA_W-1:0] rsp_data_nxt;

    assign accept_c    = (state == DBG_IDLE) && dm_cmd_valid;
    assign timer_clr_c = !((state == DBG_WAIT_IDLE) || (state == DBG_WAIT_DONE));

    el2_dbg_cmd_timer #(.TIMEOUT_W(TIMEOUT_W)) u_timer (
        .clk     (clk),
        .rst_l   (rst_l),
        .clr     (timer_clr_c),
        .inc     (!timer_clr_c),
        .expired (expired)
    );

    // Command fields load only on acceptance and hold until the next one.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            pkt_q <= '0;
        end else if (accept_c) begin
            pkt_q <= '{write:    dm_cmd_write,
                       cmd_type: dm_cmd_type,
                       addr:     dm_cmd_addr,
                       wrdata:   dm_cmd_wrdata,
                       size:     dm_cmd_size};
        end
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state <= DBG_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state plus the cmderr/data to load when entering RESP.
    always_comb begin
        state_nxt = state;
        err_c     = DBG_ERR_NONE;
        data_c    = '0;
        case (state)
            DBG_IDLE: begin
                if (accept_c) begin
                    if (dm_cmd_type == DBG_TYPE_RSVD) begin
                        state_nxt = DBG_RESP;
                        err_c     = DBG_ERR_NOTSUP;
                    end else if (dm_cmd_type == DBG_TYPE_MEM) begin
                        state_nxt = DBG_ISSUE;
                    end else if (!core_halted) begin
                        state_nxt = DBG_RESP;
                        err_c     = DBG_ERR_HALT;
                    end else if (!core_idle) begin
                        state_nxt = DBG_WAIT_IDLE;
                    end else begin
                        state_nxt = DBG_ISSUE;
                    end
                end
            end
            DBG_WAIT_IDLE: begin
                if (core_idle && core_halted) begin
                    state_nxt = DBG_ISSUE;
                end else if (!core_halted) begin
                    state_nxt = DBG_RESP;
                    err_c     = DBG_ERR_HALT;
                end else if (expired) begin
                    state_nxt = DBG_RESP;
                    err_c     = DBG_ERR_OTHER;
                end
            end
            DBG_ISSUE: state_nxt = DBG_WAIT_DONE;
            DBG_WAIT_DONE: begin
                // Halt loss is ignored here: the injected op is already in flight.
                if (dbg_cmd_done) begin
                    state_nxt = DBG_RESP;
                    if (dbg_cmd_fail) begin
                        err_c = (pkt_q.cmd_type == DBG_TYPE_MEM) ? DBG_ERR_BUS : DBG_ERR_EXC;
                    end else if (!pkt_q.write) begin
                        data_c = dbg_rddata;
                    end
                end else if (expired) begin
                    state_nxt = DBG_RESP;
                    err_c     = DBG_ERR_OTHER;
                end
            end
            DBG_RESP: begin
                if (dm_rsp_ready) begin
                    state_nxt = DBG_IDLE;
                end
            end
            default: state_nxt = DBG_IDLE;
        endcase
    end

    // Output next-values, aligned with the state register.
    always_comb begin
        cmd_ready_nxt = (state_nxt == DBG_IDLE);
        cmd_valid_nxt = (state_nxt == DBG_ISSUE);
        rsp_valid_nxt = (state_nxt == DBG_RESP);
        cmderr_nxt    = dm_rsp_cmderr;
        rsp_data_nxt  = dm_rsp_data;
        if ((state_nxt == DBG_RESP) && (state != DBG_RESP)) begin
            cmderr_nxt   = err_c;
            rsp_data_nxt = data_c;
        end
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            dm_cmd_ready  <= 1'b1;
            dbg_cmd_valid <= 1'b0;
            dm_rsp_valid  <= 1'b0;
            dm_rsp_cmderr <= '0;
            dm_rsp_data   <= '0;
        end else begin
            dm_cmd_ready  <= cmd_ready_nxt;
            dbg_cmd_valid <= cmd_valid_nxt;
            dm_rsp_valid  <= rsp_valid_nxt;
            dm_rsp_cmderr <= cmderr_nxt;
            dm_rsp_data   <= rsp_data_nxt;
        end
    end

    assign dbg_cmd_write  = pkt_q.write;
    assign dbg_cmd_type   = pkt_q.cmd_type;
    assign dbg_cmd_addr   = pkt_q.addr;
    assign dbg_cmd_wrdata = pkt_q.wrdata;
    assign dbg_cmd_size   = pkt_q.size;

endmodule

// File: tb/tb_el2_dbg_cmd_seq.sv
// Directed bench for el2_dbg_cmd_seq with a 4-bit wait counter.
module tb_el2_dbg_cmd_seq;

    logic        clk = 1'b0;
    logic        rst_l;
    logic        dm_cmd_valid, dm_cmd_ready, dm_cmd_write;
    logic [1:0]  dm_cmd_type, dm_cmd_size;
    logic [31:0] dm_cmd_addr, dm_cmd_wrdata;
    logic        core_halted, core_idle;
    logic        dbg_cmd_valid, dbg_cmd_write;
    logic [1:0]  dbg_cmd_type, dbg_cmd_size;
    logic [31:0] dbg_cmd_addr, dbg_cmd_wrdata;
    logic        dbg_cmd_done, dbg_cmd_fail;
    logic [31:0] dbg_rddata;
    logic        dm_rsp_valid, dm_rsp_ready;
    logic [2:0]  dm_rsp_cmderr;
    logic [31:0] dm_rsp_data;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    el2_dbg_cmd_seq #(.TIMEOUT_W(4)) dut (
        .clk(clk), .rst_l(rst_l),
        .dm_cmd_valid(dm_cmd_valid), .dm_cmd_ready(dm_cmd_ready),
        .dm_cmd_write(dm_cmd_write), .dm_cmd_type(dm_cmd_type),
        .dm_cmd_addr(dm_cmd_addr), .dm_cmd_wrdata(dm_cmd_wrdata),
        .dm_cmd_size(dm_cmd_size),
        .core_halted(core_halted), .core_idle(core_idle),
        .dbg_cmd_valid(dbg_cmd_valid), .dbg_cmd_write(dbg_cmd_write),
        .dbg_cmd_type(dbg_cmd_type), .dbg_cmd_addr(dbg_cmd_addr),
        .dbg_cmd_wrdata(dbg_cmd_wrdata), .dbg_cmd_size(dbg_cmd_size),
        .dbg_cmd_done(dbg_cmd_done), .dbg_cmd_fail(dbg_cmd_fail),
        .dbg_rddata(dbg_rddata),
        .dm_rsp_valid(dm_rsp_valid), .dm_rsp_ready(dm_rsp_ready),
        .dm_rsp_cmderr(dm_rsp_cmderr), .dm_rsp_data(dm_rsp_data)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one command for a single accepting edge; returns in cycle N+1.
    task automatic send(input logic wr, input logic [1:0] ty, input logic [31:0] ad,
                        input logic [31:0] wd, input logic [1:0] sz);
        dm_cmd_valid  = 1'b1;
        dm_cmd_write  = wr;
        dm_cmd_type   = ty;
        dm_cmd_addr   = ad;
        dm_cmd_wrdata = wd;
        dm_cmd_size   = sz;
        tick();
        dm_cmd_valid  = 1'b0;
    endtask

    task automatic ack(input string tag);
        dm_rsp_ready = 1'b1;
        tick();
        dm_rsp_ready = 1'b0;
        chk({tag, "_ready_after_ack"}, 32'(dm_cmd_ready), 32'd1);
    endtask

    task automatic wait_rsp(input int max, output int n, output int pulses);
        n = 0;
        pulses = 0;
        while (!dm_rsp_valid && n < max) begin
            if (dbg_cmd_valid) pulses++;
            tick();
            n++;
        end
        chk("rsp_arrived", 32'(dm_rsp_valid), 32'd1);
    endtask

    initial begin
        int n;
        int pulses;
        logic held;

        rst_l = 1'b0;
        dm_cmd_valid = 1'b0; dm_cmd_write = 1'b0; dm_cmd_type = 2'd0;
        dm_cmd_addr = '0; dm_cmd_wrdata = '0; dm_cmd_size = 2'd0;
        core_halted = 1'b1; core_idle = 1'b1;
        dbg_cmd_done = 1'b0; dbg_cmd_fail = 1'b0; dbg_rddata = '0;
        dm_rsp_ready = 1'b0;
        #23;
        chk("rst_cmd_ready", 32'(dm_cmd_ready), 32'd1);
        chk("rst_dbg_valid", 32'(dbg_cmd_valid), 32'd0);
        chk("rst_rsp_valid", 32'(dm_rsp_valid), 32'd0);
        chk("rst_cmderr", 32'(dm_rsp_cmderr), 32'd0);
        chk("rst_rsp_data", dm_rsp_data, 32'd0);
        chk("rst_dbg_addr", dbg_cmd_addr, 32'd0);
        rst_l = 1'b1;
        tick();

        // GPR read x5, halted and idle, done three cycles after acceptance
        send(1'b0, 2'd0, 32'd5, 32'd0, 2'd2);
        chk("gpr_issue_valid", 32'(dbg_cmd_valid), 32'd1);
        chk("gpr_issue_addr", dbg_cmd_addr, 32'd5);
        chk("gpr_busy_ready", 32'(dm_cmd_ready), 32'd0);
        tick();
        chk("gpr_single_pulse", 32'(dbg_cmd_valid), 32'd0);
        tick();
        dbg_cmd_done = 1'b1; dbg_rddata = 32'hDEADBEEF;
        chk("gpr_no_early_rsp", 32'(dm_rsp_valid), 32'd0);
        tick();
        dbg_cmd_done = 1'b0; dbg_rddata = '0;
        chk("gpr_rsp_valid", 32'(dm_rsp_valid), 32'd1);
        chk("gpr_cmderr", 32'(dm_rsp_cmderr), 32'd0);
        chk("gpr_rsp_data", dm_rsp_data, 32'hDEADBEEF);
        ack("gpr");
        chk("gpr_rsp_dropped", 32'(dm_rsp_valid), 32'd0);

        // CSR write while running: precondition error one cycle after accept
        core_halted = 1'b0;
        send(1'b1, 2'd1, 32'h7C4, 32'h55, 2'd2);
        chk("csr_run_no_issue", 32'(dbg_cmd_valid), 32'd0);
        chk("csr_run_rsp_valid", 32'(dm_rsp_valid), 32'd1);
        chk("csr_run_cmderr", 32'(dm_rsp_cmderr), 32'd4);
        ack("csr_run");

        // Memory write while running faults on the bus
        send(1'b1, 2'd2, 32'h1000, 32'hA5A5_0001, 2'd2);
        chk("mem_issue_valid", 32'(dbg_cmd_valid), 32'd1);
        chk("mem_issue_type", 32'(dbg_cmd_type), 32'd2);
        chk("mem_issue_wrdata", dbg_cmd_wrdata, 32'hA5A5_0001);
        tick();
        dbg_cmd_done = 1'b1; dbg_cmd_fail = 1'b1; dbg_rddata = 32'h1111_2222;
        tick();
        dbg_cmd_done = 1'b0; dbg_cmd_fail = 1'b0; dbg_rddata = '0;
        chk("mem_fail_cmderr", 32'(dm_rsp_cmderr), 32'd5);
        chk("mem_fail_data", dm_rsp_data, 32'd0);
        chk("mem_addr_held", dbg_cmd_addr, 32'h1000);
        ack("mem");

        // Halted but busy for 10 cycles, then idle
        core_halted = 1'b1; core_idle = 1'b0;
        send(1'b0, 2'd0, 32'd3, 32'd0, 2'd2);
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            if (dbg_cmd_valid || dm_rsp_valid) pulses++;
            tick();
        end
        chk("wait_idle_quiet", 32'(pulses), 32'd0);
        core_idle = 1'b1;
        tick();
        chk("wait_idle_issue", 32'(dbg_cmd_valid), 32'd1);
        tick();
        dbg_cmd_done = 1'b1; dbg_rddata = 32'h1234_5678;
        tick();
        dbg_cmd_done = 1'b0; dbg_rddata = '0;
        chk("wait_idle_cmderr", 32'(dm_rsp_cmderr), 32'd0);
        chk("wait_idle_data", dm_rsp_data, 32'h1234_5678);
        ack("wait_idle");

        // Idle never arrives: timeout from WAIT_IDLE
        core_idle = 1'b0;
        send(1'b0, 2'd1, 32'h300, 32'd0, 2'd2);
        wait_rsp(40, n, pulses);
        chk("idle_to_window", 32'(n >= 15 && n <= 16), 32'd1);
        chk("idle_to_no_issue", 32'(pulses), 32'd0);
        chk("idle_to_cmderr", 32'(dm_rsp_cmderr), 32'd7);
        ack("idle_to");
        core_idle = 1'b1;

        // GPR write with no completion, then a late done is ignored
        send(1'b1, 2'd0, 32'd7, 32'hFEED_0007, 2'd2);
        chk("nodone_issue", 32'(dbg_cmd_valid), 32'd1);
        wait_rsp(40, n, pulses);
        chk("nodone_cmderr", 32'(dm_rsp_cmderr), 32'd7);
        chk("nodone_data", dm_rsp_data, 32'd0);
        ack("nodone");
        for (int i = 0; i < 4; i++) tick();
        dbg_cmd_done = 1'b1; dbg_rddata = 32'hBADB_AD00;
        tick();
        dbg_cmd_done = 1'b0; dbg_rddata = '0;
        chk("late_done_no_rsp", 32'(dm_rsp_valid), 32'd0);
        chk("late_done_ready", 32'(dm_cmd_ready), 32'd1);
        send(1'b0, 2'd0, 32'd9, 32'd0, 2'd2);
        chk("next_issue_addr", dbg_cmd_addr, 32'd9);
        tick();
        dbg_cmd_done = 1'b1; dbg_rddata = 32'hCAFE_F00D;
        tick();
        dbg_cmd_done = 1'b0; dbg_rddata = '0;
        chk("next_cmderr", 32'(dm_rsp_cmderr), 32'd0);
        chk("next_data", dm_rsp_data, 32'hCAFE_F00D);
        ack("next");

        // Reserved type, response held under backpressure
        send(1'b0, 2'd3, 32'h42, 32'd0, 2'd2);
        chk("rsvd_cmderr", 32'(dm_rsp_cmderr), 32'd2);
        held = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (!dm_rsp_valid || dm_rsp_cmderr !== 3'd2 || dm_rsp_data !== 32'd0 ||
                dm_cmd_ready || dbg_cmd_valid) held = 1'b0;
            tick();
        end
        chk("rsvd_held_stable", 32'(held), 32'd1);
        chk("rsvd_still_valid", 32'(dm_rsp_valid), 32'd1);
        ack("rsvd");

        // Asynchronous reset while waiting for completion
        send(1'b0, 2'd0, 32'd11, 32'd0, 2'd2);
        tick();
        #1 rst_l = 1'b0;
        #1;
        chk("arst_state_idle", 32'(dut.state), 32'd0);
        chk("arst_rsp_valid", 32'(dm_rsp_valid), 32'd0);
        chk("arst_cmd_ready", 32'(dm_cmd_ready), 32'd1);
        chk("arst_dbg_addr", dbg_cmd_addr, 32'd0);
        #1 rst_l = 1'b1;
        tick();
        chk("arst_ready_after", 32'(dm_cmd_ready), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
